// File: rtl/adder_64.sv
// Registered 64-bit adder with carry-in/out built on a three-level carry-lookahead core.
// Optional signed-overflow output enabled by defining ADDER_64_OVF_EN.

module adder_64_cla #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned GROUP = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int unsigned NGRP = WIDTH / GROUP;
    localparam int unsigned NBLK = NGRP / GROUP;

    // Carries into positions 0..3 of a 4-wide lookahead unit, flattened two-level logic.
    function automatic logic [3:0] cla4(input logic [3:0] g, input logic [3:0] p,
                                        input logic c0);
        logic [3:0] c;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        return c;
    endfunction

    // {generate, propagate} of a 4-wide span.
    function automatic logic [1:0] gp4(input logic [3:0] g, input logic [3:0] p);
        logic gg;
        gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        return {gg, &p};
    endfunction

    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_c;
    logic [NGRP-1:0]  w_gg;
    logic [NGRP-1:0]  w_gp;
    logic [NGRP-1:0]  w_gc;
    logic [NBLK-1:0]  w_bg;
    logic [NBLK-1:0]  w_bp;
    logic [NBLK-1:0]  w_bc;
    logic [1:0]       w_top;

    assign w_g = a & b;
    assign w_p = a ^ b;

    always_comb begin
        w_gg = '0;
        w_gp = '0;
        for (int unsigned j = 0; j < NGRP; j++) begin
            {w_gg[j], w_gp[j]} = gp4(w_g[GROUP*j +: GROUP], w_p[GROUP*j +: GROUP]);
        end
        w_bg = '0;
        w_bp = '0;
        for (int unsigned k = 0; k < NBLK; k++) begin
            {w_bg[k], w_bp[k]} = gp4(w_gg[GROUP*k +: GROUP], w_gp[GROUP*k +: GROUP]);
        end
        w_top = gp4(w_bg, w_bp);
        w_bc  = cla4(w_bg, w_bp, cin);
        // Carries flow top-down: blocks seed groups, groups seed bits.
        w_gc = '0;
        for (int unsigned k = 0; k < NBLK; k++) begin
            w_gc[GROUP*k +: GROUP] = cla4(w_gg[GROUP*k +: GROUP], w_gp[GROUP*k +: GROUP],
                                          w_bc[k]);
        end
        w_c = '0;
        for (int unsigned j = 0; j < NGRP; j++) begin
            w_c[GROUP*j +: GROUP] = cla4(w_g[GROUP*j +: GROUP], w_p[GROUP*j +: GROUP],
                                         w_gc[j]);
        end
    end

    assign sum  = w_p ^ w_c;
    assign cout = w_top[1] | (w_top[0] & cin);
endmodule

module adder_64 #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef ADDER_64_OVF_EN
    ,
    output logic             ovf
`endif
);
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    adder_64_cla #(
        .WIDTH (WIDTH),
        .GROUP (GROUP)
    ) u_cla (
        .a    (a),
        .b    (b),
        .cin  (cin),
        .sum  (w_sum),
        .cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else begin
            r_sum  <= w_sum;
            r_cout <= w_cout;
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

`ifdef ADDER_64_OVF_EN
    logic w_ovf;
    logic r_ovf;

    // Signed overflow: like-signed operands producing a result of the other sign.
    assign w_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (rst) r_ovf <= 1'b0;
        else     r_ovf <= w_ovf;
    end

    assign ovf = r_ovf;
`endif
endmodule

// File: tb/tb_adder_64.sv
// Self-checking bench for adder_64: directed cases plus a randomized run against a
// 65-bit arithmetic reference model. Define ADDER_64_OVF_EN to also check ovf.

module tb_adder_64;
    logic        clk;
    logic        rst;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [63:0] sum;
    logic        cout;
`ifdef ADDER_64_OVF_EN
    logic        ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    adder_64 dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .sum  (sum),
        .cout (cout)
`ifdef ADDER_64_OVF_EN
        ,
        .ovf  (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive operands, let one rising edge sample them, then settle past the edge.
    task automatic step(input logic [63:0] ta, input logic [63:0] tb, input logic tc);
        a   = ta;
        b   = tb;
        cin = tc;
        @(posedge clk);
        #1;
    endtask

    // Reference: plain 65-bit sum of the sampled operands.
    function automatic logic [64:0] ref_add(input logic [63:0] ta, input logic [63:0] tb,
                                            input logic tc);
        return {1'b0, ta} + {1'b0, tb} + {64'd0, tc};
    endfunction

    task automatic test_reset();
        logic [64:0] exp;
        rst = 1'b1;
        step(64'd80, 64'd4, 1'b0);
        n_cmp++;
        if ({cout, sum} !== 65'd0) begin
            n_err++;
            $display("FAIL reset_hold: got cout=%b sum=%h, want 0/0", cout, sum);
        end
        step('1, '1, 1'b1);
        n_cmp++;
        if ({cout, sum} !== 65'd0) begin
            n_err++;
            $display("FAIL reset_dominates: got cout=%b sum=%h, want 0/0", cout, sum);
        end
        rst = 1'b0;
        step(64'd80, 64'd4, 1'b0);
        exp = ref_add(64'd80, 64'd4, 1'b0);
        n_cmp++;
        if ({cout, sum} !== exp) begin
            n_err++;
            $display("FAIL reset_release: got cout=%b sum=%h, want %h", cout, sum, exp);
        end
        step('1, 64'd7, 1'b1);
        rst = 1'b1;
        step('1, 64'd7, 1'b1);
        n_cmp++;
        if ({cout, sum} !== 65'd0) begin
            n_err++;
            $display("FAIL reset_midstream: got cout=%b sum=%h, want 0/0", cout, sum);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [63:0] ta[4] = '{64'd80, 64'd80, 64'd4, 64'd4};
        logic [63:0] tb[4] = '{64'd4, 64'd4, 64'd80, 64'd80};
        logic        tc[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [64:0] want[4] = '{65'd84, 65'd85, 65'd85, 65'd84};
        for (int i = 0; i < 4; i++) begin
            step(ta[i], tb[i], tc[i]);
            n_cmp++;
            if ({cout, sum} !== want[i]) begin
                n_err++;
                $display("FAIL basic_%0d: got cout=%b sum=%0d, want %0d", i, cout, sum, want[i]);
            end
        end
    endtask

    task automatic test_carry();
        logic [63:0] ta[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                               64'h0000_0000_FFFF_FFFF, 64'hAAAA_AAAA_AAAA_AAAA};
        logic [63:0] tb[4] = '{64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h5555_5555_5555_5555};
        logic        tc[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [64:0] want[4] = '{{1'b1, 64'd0}, {1'b1, 64'hFFFF_FFFF_FFFF_FFFF},
                                 {1'b0, 64'h0000_0001_0000_0000}, {1'b1, 64'd0}};
        for (int i = 0; i < 4; i++) begin
            step(ta[i], tb[i], tc[i]);
            n_cmp++;
            if ({cout, sum} !== want[i]) begin
                n_err++;
                $display("FAIL carry_%0d: got cout=%b sum=%h, want %h", i, cout, sum, want[i]);
            end
        end
    endtask

    // Inputs move between edges; registered outputs must not.
    task automatic test_stable();
        logic [64:0] held;
        step(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1);
        held = {cout, sum};
        a   = '1;
        b   = 64'd1;
        cin = 1'b0;
        #2;
        n_cmp++;
        if ({cout, sum} !== 65'h0_2222_2222_2222_2212) begin
            n_err++;
            $display("FAIL stable: got cout=%b sum=%h, want 0_2222222222222212 (held %h)",
                     cout, sum, held);
        end
    endtask

`ifdef ADDER_64_OVF_EN
    task automatic test_ovf();
        step(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        n_cmp++;
        if ({ovf, cout, sum} !== {1'b1, 1'b0, 64'h8000_0000_0000_0000}) begin
            n_err++;
            $display("FAIL ovf_pos: got ovf=%b cout=%b sum=%h, want 1/0/8000000000000000",
                     ovf, cout, sum);
        end
        step(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
        n_cmp++;
        if ({ovf, cout, sum} !== {1'b1, 1'b1, 64'd0}) begin
            n_err++;
            $display("FAIL ovf_neg: got ovf=%b cout=%b sum=%h, want 1/1/0", ovf, cout, sum);
        end
        step(64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
        n_cmp++;
        if ({ovf, cout, sum} !== {1'b0, 1'b1, 64'd0}) begin
            n_err++;
            $display("FAIL ovf_mixed: got ovf=%b cout=%b sum=%h, want 0/1/0", ovf, cout, sum);
        end
    endtask
`endif

    // Back-to-back random stream, one new operation every cycle.
    task automatic test_random(input int n);
        logic [63:0] ra;
        logic [63:0] rb;
        logic        rc;
        logic [64:0] exp;
        int          bad = 0;
        for (int i = 0; i < n; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rc = 1'($urandom);
            case ($urandom_range(0, 3))
                0: rb = ~ra;
                1: rb = ra ^ (64'd1 << $urandom_range(0, 63));
                default: ;
            endcase
            step(ra, rb, rc);
            exp = ref_add(ra, rb, rc);
            n_cmp++;
            if ({cout, sum} !== exp) begin
                n_err++;
                if (bad++ < 10)
                    $display("FAIL random_%0d: a=%h b=%h cin=%b got %b_%h, want %h",
                             i, ra, rb, rc, cout, sum, exp);
            end
`ifdef ADDER_64_OVF_EN
            n_cmp++;
            if (ovf !== ((ra[63] == rb[63]) && (exp[63] != ra[63]))) begin
                n_err++;
                if (bad++ < 10)
                    $display("FAIL random_ovf_%0d: a=%h b=%h cin=%b got ovf=%b", i, ra, rb, rc,
                             ovf);
            end
`endif
        end
    endtask

    initial begin
        rst = 1'b1;
        a   = '0;
        b   = '0;
        cin = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_carry();
        test_stable();
`ifdef ADDER_64_OVF_EN
        test_ovf();
`endif
        test_random(10000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/adder_64.md
Name: adder_64

Overview:
- 64-bit binary adder with carry-in and carry-out. Outputs are registered.
- Core is a hierarchical carry-lookahead network; no ripple chain through all 64 bits.
- Used as the add primitive inside the processing-element datapath.
- One clock domain; synchronous, active-high reset.

Parameters:
- WIDTH, 64, operand and sum width. Fixed at 64; other values unsupported. Present only for documentation and port sizing.
- GROUP, 4, bits per first-level lookahead group. Fixed at 4.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- a  input  64  unsigned operand A.
- b  input  64  unsigned operand B.
- cin  input  1  carry into bit 0.
- sum  output  64  registered low 64 bits of a+b+cin.
- cout  output  1  registered carry out of bit 63.

Behaviour:
- Clocking and reset: one clock (clk). Reset rst is synchronous and active-high.
- Reset: on a rising clk edge with rst=1, sum<=0, cout<=0 (and ovf<=0 when present). rst dominates all inputs.
- Normal operation: on each rising clk edge with rst=0, a, b and cin are sampled.
  - {cout,sum} <= a + b + cin, computed as a 65-bit unsigned result.
  - Latency is exactly 1 cycle; throughput is 1 result per cycle.
  - There is no handshake or valid signal; every cycle is a new operation.
- Outputs change only at clock edges; between edges they are stable regardless of input activity.
- Arithmetic is modulo 2^64. cout=1 exactly when a+b+cin >= 2^64.
  - Wrap-around example: a=FFFF_FFFF_FFFF_FFFF, b=0, cin=1 gives sum=0, cout=1.
  - Maximum case: a=b=all-ones, cin=1 gives sum=all-ones, cout=1.
- Carry structure:
  - Per bit: g=a&b, p=a^b.
  - 16 groups of 4 bits, each producing group G/P and internal carries via lookahead.
  - Second level: 4 blocks of 4 groups, producing block G/P.
  - Top level: lookahead across the 4 blocks, seeded by cin.
  - Sum bit i = p[i] ^ c[i]. cout = carry out of the top level.
  - The combinational core is a separate submodule; the register stage lives in adder_64.
- Reset asserted mid-stream: the next edge clears the outputs. The first result after rst deasserts reflects inputs sampled at the first edge with rst=0.
- X or Z on inputs is not handled specially.

Optional Feature:
- Macro: ADDER_64_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit, registered, same latency as sum).
  - ovf = (a[63]==b[63]) && (sum_next[63]!=a[63]), i.e. two's-complement signed overflow of a+b+cin.
  - Reset value 0.
- Undefined: no ovf port and no ovf logic. All other behaviour is identical.

Test Plan:
- Basic add: a=80, b=4, cin=0 -> after 1 clk: sum=84, cout=0. Then cin=1 -> sum=85, cout=0.
- Operand swap: a=4, b=80, cin=1 -> sum=85. Then cin=0 -> sum=84, cout=0. Confirms commutativity and that cin toggling is tracked each cycle.
- Carry chain and wrap:
  - a=FFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> sum=0, cout=1.
  - a=b=FFFF_FFFF_FFFF_FFFF, cin=1 -> sum=FFFF_FFFF_FFFF_FFFF, cout=1.
  - a=0000_0000_FFFF_FFFF, b=1, cin=0 -> sum=0000_0001_0000_0000, cout=0.
- Reset:
  - Hold rst=1 with a=80, b=4 -> sum=0, cout=0.
  - Deassert rst -> next edge gives sum=84.
  - Assert rst mid-stream -> outputs return to 0 at the following edge.
- Overflow (ADDER_64_OVF_EN defined):
  - a=7FFF_FFFF_FFFF_FFFF, b=1, cin=0 -> sum=8000_0000_0000_0000, ovf=1, cout=0.
  - a=8000_0000_0000_0000, b=8000_0000_0000_0000 -> sum=0, ovf=1, cout=1.
- Random regression: 10k random a/b/cin compared against a 65-bit reference sum delayed one cycle -> zero mismatches.
